// File: rtl/nios2_fp_cpu_ocimem_ctrl.sv
// OCI debug-memory controller: JTAG monitor reads/writes and a CPU Avalon-MM port sharing one RAM.
// Optional: define NIOS2_FP_OCIMEM_DEBUGACK_GATE_EN to refuse JTAG writes unless debugack is high.
module nios2_fp_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, JRD, JCAP, JWR} state_t;

  localparam int unsigned DEPTH_U = DEPTH;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_mon_d;
  logic [ADDR_W-1:0] r_mon_a;
  logic              r_ready, r_error;
  logic              r_a_done;     // address-only ocimem_a: ready rises one edge later
  logic              r_wr_ok;
  logic              r_cpu_rvalid, r_cpu_rd_ok;
  logic [31:0]       r_ram_q;
  logic [31:0]       r_mem [DEPTH];

  logic              w_str_a, w_str_b, w_str_n, w_str_any, w_idle, w_wr_allow;
  logic              w_jtag_in_rng, w_cpu_in_rng, w_cpu_acc_wr, w_cpu_acc_rd;
  logic              w_mem_we, w_mem_re;
  logic [3:0]        w_mem_be;
  logic [31:0]       w_mem_wdata;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [4:0]        w_unused_jdo;

`ifdef NIOS2_FP_OCIMEM_DEBUGACK_GATE_EN
  assign w_wr_allow = debugack;
`else
  logic w_unused_debugack;
  assign w_wr_allow        = 1'b1;
  assign w_unused_debugack = debugack;
`endif

  assign w_unused_jdo = {jdo[37:36], jdo[2:0]};

  // Strobe priority: ocimem_b > ocimem_a > no_action.
  assign w_str_b   = take_action_ocimem_b;
  assign w_str_a   = take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_str_n   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_str_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_idle    = (r_state == IDLE);

  assign w_jtag_in_rng = 32'(r_mon_a) < DEPTH_U;
  assign w_cpu_in_rng  = 32'(cpu_address) < DEPTH_U;

  assign cpu_waitrequest = ~w_idle | w_str_any;
  assign w_cpu_acc_wr    = ~cpu_waitrequest & cpu_write;
  assign w_cpu_acc_rd    = ~cpu_waitrequest & cpu_read & ~cpu_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_str_b)                  w_state_nxt = JWR;
        else if (w_str_a && jdo[35])  w_state_nxt = JRD;
        else if (w_str_n)             w_state_nxt = JRD;
      end
      JRD:     w_state_nxt = JCAP;
      JCAP:    w_state_nxt = IDLE;
      JWR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon_d      <= '0;
      r_mon_a      <= '0;
      r_ready      <= 1'b0;
      r_error      <= 1'b0;
      r_a_done     <= 1'b0;
      r_wr_ok      <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_cpu_rd_ok  <= 1'b0;
    end else begin
      r_a_done     <= 1'b0;
      r_cpu_rvalid <= w_cpu_acc_rd;
      r_cpu_rd_ok  <= w_cpu_in_rng;
      if (r_a_done) r_ready <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_str_b) begin
            r_mon_d <= jdo[34:3];
            r_ready <= 1'b0;
            r_wr_ok <= w_wr_allow;
          end else if (w_str_a) begin
            r_mon_a  <= jdo[17 +: ADDR_W];
            r_ready  <= 1'b0;
            r_error  <= 1'b0;
            r_a_done <= ~jdo[35];
          end else if (w_str_n) begin
            r_ready <= 1'b0;
          end
        end
        JCAP: begin
          r_mon_d <= w_jtag_in_rng ? r_ram_q : 32'd0;
          r_mon_a <= r_mon_a + 1'b1;
          r_ready <= 1'b1;
          if (!w_jtag_in_rng) r_error <= 1'b1;
        end
        JWR: begin
          r_ready <= 1'b1;
          if (r_wr_ok) begin
            r_mon_a <= r_mon_a + 1'b1;
            if (!w_jtag_in_rng) r_error <= 1'b1;
          end else begin
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
      // A strobe arriving while busy is dropped and flagged; the in-flight operation still completes.
      if (!w_idle && w_str_any) r_error <= 1'b1;
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_be    = '0;
    w_mem_wdata = cpu_writedata;
    w_mem_addr  = cpu_address;
    case (r_state)
      IDLE: begin
        w_mem_we = w_cpu_acc_wr & w_cpu_in_rng;
        w_mem_re = w_cpu_acc_rd & w_cpu_in_rng;
        w_mem_be = cpu_byteenable;
      end
      JRD: begin
        w_mem_addr = r_mon_a;
        w_mem_re   = w_jtag_in_rng;
      end
      JWR: begin
        w_mem_addr  = r_mon_a;
        w_mem_we    = r_wr_ok & w_jtag_in_rng;
        w_mem_be    = 4'hF;
        w_mem_wdata = r_mon_d;
      end
      default: ;
    endcase
  end

  // NOTE: RAM array and its read register have no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
    if (w_mem_re) r_ram_q <= r_mem[w_mem_addr];
  end

  assign cpu_readdata      = (r_cpu_rvalid && r_cpu_rd_ok) ? r_ram_q : 32'd0;
  assign cpu_readdatavalid = r_cpu_rvalid;
  assign MonDReg           = r_mon_d;
  assign MonAReg           = r_mon_a;
  assign monitor_ready     = r_ready;
  assign monitor_error     = r_error;

endmodule

// File: tb/tb_nios2_fp_cpu_ocimem_ctrl.sv
// Self-checking bench for nios2_fp_cpu_ocimem_ctrl: directed scenarios plus random JTAG/CPU traffic
// checked against a transaction-level model (array RAM + monitor register values).
module tb_nios2_fp_cpu_ocimem_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic              debugack;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read, cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_readdatavalid, cpu_waitrequest;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready, monitor_error;

  nios2_fp_cpu_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .debugack                (debugack),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: RAM contents and the JTAG-visible monitor registers.
  logic [31:0]       ref_mem [256];
  logic [ADDR_W-1:0] m_a;
  logic [31:0]       m_d;
  logic              m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_read();
    if (m_a < DEPTH) m_d = ref_mem[m_a];
    else begin
      m_d   = 32'd0;
      m_err = 1'b1;
    end
    m_a = m_a + 1'b1;
  endtask

  task automatic model_write(input logic [31:0] data);
    logic ok;
    ok  = 1'b1;
`ifdef NIOS2_FP_OCIMEM_DEBUGACK_GATE_EN
    ok  = debugack;
`endif
    m_d = data;
    if (ok) begin
      if (m_a < DEPTH) ref_mem[m_a] = data;
      else m_err = 1'b1;
      m_a = m_a + 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_mon(input string tag);
    check({tag, "_mond"}, MonDReg, m_d);
    check({tag, "_mona"}, 32'(MonAReg), 32'(m_a));
    check({tag, "_rdy"},  32'(monitor_ready), 32'd1);
    check({tag, "_err"},  32'(monitor_error), 32'(m_err));
  endtask

  // kind: 0=ocimem_a, 1=ocimem_b, 2=no_action, 3=a+b together, 4=a+no_action together
  task automatic jtag_op(input int kind, input logic [ADDR_W-1:0] addr, input logic rd,
                         input logic [31:0] data, input string tag);
    int lat;
    int exp_lat;
    jdo = {6'($urandom), $urandom};
    if (kind == 1 || kind == 3) jdo[34:3] = data;
    else begin
      jdo[35]            = rd;
      jdo[17 +: ADDR_W]  = addr;
    end
    take_action_ocimem_a    = (kind == 0 || kind == 3 || kind == 4);
    take_action_ocimem_b    = (kind == 1 || kind == 3);
    take_no_action_ocimem_a = (kind == 2 || kind == 4);
    #1;
    check({tag, "_wreq"}, 32'(cpu_waitrequest), 32'd1);
    if (kind == 1 || kind == 3) begin
      model_write(jdo[34:3]);
      exp_lat = 1;
    end else if (kind == 0 || kind == 4) begin
      m_a   = jdo[17 +: ADDR_W];
      m_err = 1'b0;
      if (jdo[35]) begin
        model_read();
        exp_lat = 2;
      end else exp_lat = 1;
    end else begin
      model_read();
      exp_lat = 2;
    end
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    check({tag, "_rdy0"}, 32'(monitor_ready), 32'd0);
    lat = 0;
    while (!monitor_ready && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_mon(tag);
  endtask

  task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_address    = a;
    cpu_writedata  = d;
    cpu_byteenable = be;
    cpu_write      = 1'b1;
    #1;
    check("cpu_wr_wreq", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_write = 1'b0;
    check("cpu_wr_norv", 32'(cpu_readdatavalid), 32'd0);
    if (a < DEPTH) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic cpu_rd(input logic [ADDR_W-1:0] a, input string tag);
    int n;
    cpu_address = a;
    cpu_read    = 1'b1;
    #1;
    n = 0;
    while (cpu_waitrequest && n < 16) begin
      tick();
      n++;
    end
    check({tag, "_acc"}, 32'(n < 16), 32'd1);
    tick();
    cpu_read = 1'b0;
    check({tag, "_rv"},   32'(cpu_readdatavalid), 32'd1);
    check({tag, "_data"}, cpu_readdata, (a < DEPTH) ? ref_mem[a] : 32'd0);
    tick();
    check({tag, "_rv0"},  32'(cpu_readdatavalid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    debugack = 1'b1;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;
    m_a = '0; m_d = '0; m_err = 1'b0;

    tick(); tick();
    check("rst_mond", MonDReg, 32'd0);
    check("rst_mona", 32'(MonAReg), 32'd0);
    check("rst_rdy",  32'(monitor_ready), 32'd0);
    check("rst_err",  32'(monitor_error), 32'd0);
    check("rst_rdat", cpu_readdata, 32'd0);
    check("rst_rv",   32'(cpu_readdatavalid), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 256; i++) cpu_wr(8'(i), $urandom, 4'hF);

    // JTAG write then readback with streamed reads.
    jtag_op(0, 8'h10, 1'b0, 32'd0, "a_set");
    jtag_op(1, '0, 1'b0, 32'hCAFEF00D, "b_wr");
    check("b_wr_a11", 32'(MonAReg), 32'h11);
    jtag_op(0, 8'h10, 1'b1, 32'd0, "a_rd");
    check("a_rd_val", MonDReg, 32'hCAFEF00D);
    jtag_op(2, '0, 1'b0, 32'd0, "n1");
    jtag_op(2, '0, 1'b0, 32'd0, "n2");
    check("n2_a13", 32'(MonAReg), 32'h13);

    // Out-of-range read at 0xFF, then wrap to 0x00.
    jtag_op(0, 8'hFF, 1'b1, 32'd0, "a_oor");
    check("a_oor_err", 32'(monitor_error), 32'd1);
    jtag_op(2, '0, 1'b0, 32'd0, "n_wrap");
    check("n_wrap_a1", 32'(MonAReg), 32'h01);

    // CPU read collides with a JTAG strobe: stalled until IDLE, then served.
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[17 +: ADDR_W] = 8'h10;
    take_action_ocimem_a = 1'b1;
    cpu_address = 8'h10;
    cpu_read = 1'b1;
    #1;
    check("col_wreq", 32'(cpu_waitrequest), 32'd1);
    m_a = 8'h10; m_err = 1'b0;
    model_read();
    tick();
    take_action_ocimem_a = 1'b0;
    n = 0;
    while (cpu_waitrequest && n < 10) begin
      check("col_norv", 32'(cpu_readdatavalid), 32'd0);
      tick();
      n++;
    end
    check("col_stall", 32'(n), 32'd2);
    check_mon("col");
    tick();
    cpu_read = 1'b0;
    check("col_rv",   32'(cpu_readdatavalid), 32'd1);
    check("col_data", cpu_readdata, 32'hCAFEF00D);
    tick();
    check("col_rv0",  32'(cpu_readdatavalid), 32'd0);

    // Byte-lane write.
    cpu_wr(8'h20, 32'h12345678, 4'b0011);
    cpu_rd(8'h20, "be");

    // Read and write together: write wins, no readdatavalid.
    cpu_address = 8'h21; cpu_writedata = 32'hA5A55A5A; cpu_byteenable = 4'hF;
    cpu_read = 1'b1; cpu_write = 1'b1;
    #1;
    check("rw_wreq", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_read = 1'b0; cpu_write = 1'b0;
    check("rw_norv", 32'(cpu_readdatavalid), 32'd0);
    ref_mem[8'h21] = 32'hA5A55A5A;
    tick();
    check("rw_norv2", 32'(cpu_readdatavalid), 32'd0);
    cpu_rd(8'h21, "rw");

    // Strobe while busy: dropped and flagged, the read completes.
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[17 +: ADDR_W] = 8'h05;
    take_action_ocimem_a = 1'b1;
    m_a = 8'h05; m_err = 1'b0;
    model_read();
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = {6'($urandom), $urandom};
    take_action_ocimem_b = 1'b1;
    m_err = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
    check_mon("busy");
    cpu_rd(8'h06, "busy_nowr");

    // Write gating on debugack (effective only with the gate macro).
    jtag_op(0, 8'h40, 1'b0, 32'd0, "g_set");
    debugack = 1'b0;
    jtag_op(1, '0, 1'b0, 32'h0BAD0BAD, "g_wr0");
    cpu_rd(8'h40, "g_rd0");
    debugack = 1'b1;
    jtag_op(1, '0, 1'b0, 32'h600DF00D, "g_wr1");
    cpu_rd(8'h40, "g_rd1");
    cpu_rd(8'h41, "g_rd2");

    // Out-of-range JTAG write, then coincident strobes.
    jtag_op(0, 8'hF0, 1'b0, 32'd0, "oorw_set");
    jtag_op(1, '0, 1'b0, 32'h11112222, "oorw");
    jtag_op(3, 8'h33, 1'b1, 32'h76543210, "pri_ab");
    jtag_op(4, 8'h34, 1'b1, 32'd0, "pri_an");

    // Random mixed traffic.
    for (int it = 0; it < 120; it++) begin
      int sel;
      sel = $urandom_range(0, 6);
      debugack = 1'($urandom_range(0, 3) != 0);
      case (sel)
        0: jtag_op(0, 8'($urandom), 1'($urandom), 32'd0, "r_a");
        1: jtag_op(1, '0, 1'b0, $urandom, "r_b");
        2: jtag_op(2, '0, 1'b0, 32'd0, "r_n");
        3: cpu_wr(8'($urandom), $urandom, 4'($urandom));
        4: cpu_rd(8'($urandom), "r_cpu");
        5: jtag_op(3, 8'($urandom), 1'($urandom), $urandom, "r_ab");
        default: jtag_op(4, 8'($urandom), 1'($urandom), 32'd0, "r_an");
      endcase
    end
    debugack = 1'b1;

    // Reset during JWR: write lost, outputs back to reset values.
    jtag_op(0, 8'h30, 1'b0, 32'd0, "rs_set");
    jdo = '0;
    jdo[34:3] = 32'hDEADBEEF;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rsw_mond", MonDReg, 32'd0);
    check("rsw_mona", 32'(MonAReg), 32'd0);
    check("rsw_rdy",  32'(monitor_ready), 32'd0);
    check("rsw_err",  32'(monitor_error), 32'd0);
    check("rsw_rdat", cpu_readdata, 32'd0);
    check("rsw_rv",   32'(cpu_readdatavalid), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    m_a = '0; m_d = '0; m_err = 1'b0;
    tick();
    check("rsw_idle", 32'(cpu_waitrequest), 32'd0);
    cpu_rd(8'h30, "rsw_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
